// File: rtl/ram_responder_if.sv
// Memory handshake between the control unit (master) and the RAM responder (slave).
// MOV is held by the master until MOC is seen; MOC/err/data_out are valid while MOC is high.
interface ram_responder_if #(
  parameter int ADDR_W = 9
);
  logic              MOV;
  logic              RW;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              MOC;
  logic              err;

  modport master (
    output MOV, RW, size, sign_ext, address, data_in,
    input  data_out, MOC, err
  );

  modport slave (
    input  MOV, RW, size, sign_ext, address, data_in,
    output data_out, MOC, err
  );
endinterface

// File: rtl/ram_responder.sv
// Byte-addressed big-endian RAM answering the MOV/MOC handshake after a
// programmable number of wait states; flags misaligned halfword/word accesses.
module ram_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  ram_responder_if.slave       bus,
  output logic [1:0]           state_dbg
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              moc_q, moc_n;
  logic              err_q, err_n;
  logic [31:0]       dout_q, dout_n;
  logic              capture;
  logic              mem_we;

  logic              req_rw;
  logic [1:0]        req_size;
  logic              req_sx;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;

  logic [7:0]        mem [DEPTH];

  logic [ADDR_W-1:0] a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic              misaligned;
  logic [31:0]       rd_val;

  // Byte lanes follow the address; the increments wrap modulo the memory depth.
  assign a1 = req_addr + ADDR_W'(1);
  assign a2 = req_addr + ADDR_W'(2);
  assign a3 = req_addr + ADDR_W'(3);
  assign b0 = mem[req_addr];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));

  always_comb begin
    rd_val = '0;
    case (req_size)
      2'b00:   rd_val = {{24{req_sx & b0[7]}}, b0};
      2'b01:   rd_val = {{16{req_sx & b0[7]}}, b0, b1};
      default: rd_val = {b0, b1, b2, b3};
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    moc_n   = moc_q;
    err_n   = err_q;
    dout_n  = dout_q;
    capture = 1'b0;
    mem_we  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MOV) begin
          capture = 1'b1;
          cnt_n   = WAIT_LD;
          state_n = (WAIT_LD == 4'd0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        // Dropping MOV during the wait states cancels the request outright.
        if (!bus.MOV) begin
          cnt_n   = 4'd0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
          if (cnt == 4'd1) state_n = ACCESS;
        end
      end
      ACCESS: begin
        moc_n   = 1'b1;
        state_n = HOLD;
        if (misaligned) begin
          err_n  = 1'b1;
          dout_n = '0;
        end else begin
          err_n = 1'b0;
          if (req_rw) dout_n = rd_val;
          else        mem_we = 1'b1;
        end
      end
      HOLD: begin
        if (!bus.MOV) begin
          moc_n   = 1'b0;
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      cnt      <= '0;
      moc_q    <= 1'b0;
      err_q    <= 1'b0;
      dout_q   <= '0;
      req_rw   <= 1'b0;
      req_size <= '0;
      req_sx   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      moc_q  <= moc_n;
      err_q  <= err_n;
      dout_q <= dout_n;
      if (capture) begin
        req_rw   <= bus.RW;
        req_size <= bus.size;
        req_sx   <= bus.sign_ext;
        req_addr <= bus.address;
        req_data <= bus.data_in;
      end
    end
  end

  // Storage has no reset; a reset only ever aborts a pending write via the FSM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      case (req_size)
        2'b00: mem[req_addr] <= req_data[7:0];
        2'b01: begin
          mem[req_addr] <= req_data[15:8];
          mem[a1]       <= req_data[7:0];
        end
        default: begin
          mem[req_addr] <= req_data[31:24];
          mem[a1]       <= req_data[23:16];
          mem[a2]       <= req_data[15:8];
          mem[a3]       <= req_data[7:0];
        end
      endcase
    end
  end

  assign bus.MOC      = moc_q;
  assign bus.err      = err_q;
  assign bus.data_out = dout_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: two instances (2 and 0 wait states) driven with directed
// and random transfers, checked against a byte-array reference of the RAM.
module tb_ram_responder;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;
  localparam int W0    = 2;
  localparam int W1    = 0;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic          mov_d  [2];
  logic          rw_d   [2];
  logic          sx_d   [2];
  logic [1:0]    size_d [2];
  logic [AW-1:0] addr_d [2];
  logic [31:0]   din_d  [2];
  logic [31:0]   dout_w [2];
  logic          moc_w  [2];
  logic          err_w  [2];
  logic [1:0]    st_w   [2];

  ram_responder_if #(.ADDR_W(AW)) bus0 ();
  ram_responder_if #(.ADDR_W(AW)) bus1 ();

  assign bus0.MOV = mov_d[0];  assign bus1.MOV = mov_d[1];
  assign bus0.RW = rw_d[0];    assign bus1.RW = rw_d[1];
  assign bus0.size = size_d[0]; assign bus1.size = size_d[1];
  assign bus0.sign_ext = sx_d[0]; assign bus1.sign_ext = sx_d[1];
  assign bus0.address = addr_d[0]; assign bus1.address = addr_d[1];
  assign bus0.data_in = din_d[0]; assign bus1.data_in = din_d[1];
  assign dout_w[0] = bus0.data_out; assign dout_w[1] = bus1.data_out;
  assign moc_w[0] = bus0.MOC;  assign moc_w[1] = bus1.MOC;
  assign err_w[0] = bus0.err;  assign err_w[1] = bus1.err;

  ram_responder #(.ADDR_W(AW), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .clr(clr), .bus(bus0.slave), .state_dbg(st_w[0]));
  ram_responder #(.ADDR_W(AW), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .clr(clr), .bus(bus1.slave), .state_dbg(st_w[1]));

  // Reference model: RAM image and last completed read value per instance.
  logic [7:0]  ref_mem   [2][DEPTH];
  logic [31:0] last_dout [2];
  logic [31:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  task automatic model_op(input int d, input bit r, input logic [1:0] sz, input bit sx,
                          input logic [AW-1:0] a, input logic [31:0] wd,
                          output logic [31:0] exp_d, output logic exp_e);
    int n;
    int ai;
    logic [31:0] v;
    n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    ai = int'(a);
    exp_e = ((ai % n) != 0);
    if (exp_e) begin
      exp_d = 32'h0;
      last_dout[d] = 32'h0;
    end else if (r) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[d][(ai + i) % DEPTH]);
      if (sx && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
      exp_d = v;
      last_dout[d] = v;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[d][(ai + i) % DEPTH] = 8'(wd >> (8*(n-1-i)));
      exp_d = last_dout[d];
    end
  endtask

  // Full transfer on instance d; assumes the caller is at a falling edge.
  task automatic do_op(input int d, input bit r, input logic [1:0] sz, input bit sx,
                       input logic [AW-1:0] a, input logic [31:0] wd, input int hold,
                       output logic [31:0] got_d, output logic got_e);
    logic [31:0] exp_d;
    logic        exp_e;
    logic [31:0] sb;
    int          lat;
    model_op(d, r, sz, sx, a, wd, exp_d, exp_e);
    exp_q.push_back(exp_d);
    rw_d[d] = r; size_d[d] = sz; sx_d[d] = sx; addr_d[d] = a; din_d[d] = wd;
    mov_d[d] = 1'b1;
    @(posedge clk);
    #1;
    rw_d[d] = 1'($urandom); size_d[d] = 2'($urandom); sx_d[d] = 1'($urandom);
    addr_d[d] = AW'($urandom); din_d[d] = $urandom;
    lat = 0;
    @(negedge clk);
    while (!moc_w[d] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq($sformatf("latency_d%0d", d), 32'(lat), 32'(wait_of(d) + 1));
    sb = exp_q.pop_front();
    got_d = dout_w[d];
    got_e = err_w[d];
    check_eq($sformatf("data_d%0d", d), dout_w[d], sb);
    check_eq($sformatf("err_d%0d", d), 32'(err_w[d]), 32'(exp_e));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_moc", 32'(moc_w[d]), 32'h1);
      check_eq("hold_data", dout_w[d], sb);
      check_eq("hold_err", 32'(err_w[d]), 32'(exp_e));
    end
    mov_d[d] = 1'b0;
    @(negedge clk);
    check_eq("drop_moc", 32'(moc_w[d]), 32'h0);
    check_eq("drop_err", 32'(err_w[d]), 32'h0);
    check_eq("drop_data", dout_w[d], sb);
  endtask

  logic [31:0] gd;
  logic        ge;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      mov_d[d] = 1'b0; rw_d[d] = 1'b0; sx_d[d] = 1'b0; size_d[d] = 2'b00;
      addr_d[d] = '0; din_d[d] = '0; last_dout[d] = 32'h0;
    end
    clr = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("reset_moc", 32'(moc_w[d]), 32'h0);
      check_eq("reset_err", 32'(err_w[d]), 32'h0);
      check_eq("reset_data", dout_w[d], 32'h0);
      check_eq("reset_state", 32'(st_w[d]), 32'h0);
    end
    clr = 1'b1;
    @(negedge clk);

    // Give both RAMs a known image.
    for (int w = 0; w < DEPTH / 4; w++) begin
      do_op(0, 1'b0, 2'b10, 1'b0, AW'(w * 4), $urandom, 0, gd, ge);
      do_op(1, 1'b0, 2'b10, 1'b0, AW'(w * 4), $urandom, 0, gd, ge);
    end

    // Word write, word read, byte read.
    do_op(0, 1'b0, 2'b10, 1'b0, 9'h010, 32'hA1B2C3D4, 0, gd, ge);
    do_op(0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 0, gd, ge);
    check_eq("tp1_word", gd, 32'hA1B2C3D4);
    do_op(0, 1'b1, 2'b00, 1'b0, 9'h011, 32'h0, 0, gd, ge);
    check_eq("tp1_byte", gd, 32'h000000B2);

    // Halfword with sign/zero extension.
    do_op(0, 1'b0, 2'b01, 1'b0, 9'h020, 32'h000080F0, 0, gd, ge);
    do_op(0, 1'b1, 2'b01, 1'b1, 9'h020, 32'h0, 0, gd, ge);
    check_eq("tp2_hw_sx", gd, 32'hFFFF80F0);
    do_op(0, 1'b1, 2'b01, 1'b0, 9'h020, 32'h0, 0, gd, ge);
    check_eq("tp2_hw_zx", gd, 32'h000080F0);
    do_op(0, 1'b1, 2'b00, 1'b1, 9'h021, 32'h0, 0, gd, ge);
    check_eq("tp2_byte_sx", gd, 32'hFFFFFFF0);

    // Misaligned accesses.
    do_op(0, 1'b0, 2'b10, 1'b0, 9'h013, 32'h12345678, 0, gd, ge);
    check_eq("tp3_wr_err", 32'(ge), 32'h1);
    do_op(0, 1'b1, 2'b01, 1'b0, 9'h015, 32'h0, 0, gd, ge);
    check_eq("tp3_rd_err", 32'(ge), 32'h1);
    check_eq("tp3_rd_data", gd, 32'h0);
    do_op(0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 0, gd, ge);
    check_eq("tp3_unchanged", gd, 32'hA1B2C3D4);

    // Abort during the wait states.
    rw_d[0] = 1'b0; size_d[0] = 2'b10; addr_d[0] = 9'h030; din_d[0] = 32'hDEADBEEF;
    mov_d[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mov_d[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("abort_moc", 32'(moc_w[0]), 32'h0);
    end
    check_eq("abort_state", 32'(st_w[0]), 32'h0);
    do_op(0, 1'b1, 2'b10, 1'b0, 9'h030, 32'h0, 0, gd, ge);
    check_eq("abort_not_written", 32'(gd == 32'hDEADBEEF), 32'h0);

    // Long hold, then back-to-back zero-wait transfers.
    do_op(0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 5, gd, ge);
    do_op(1, 1'b0, 2'b10, 1'b0, 9'h100, 32'hCAFEF00D, 0, gd, ge);
    do_op(1, 1'b1, 2'b10, 1'b0, 9'h100, 32'h0, 0, gd, ge);
    check_eq("b2b_read", gd, 32'hCAFEF00D);

    // Reset in the middle of a wait state.
    rw_d[0] = 1'b0; size_d[0] = 2'b10; addr_d[0] = 9'h040; din_d[0] = 32'h11223344;
    mov_d[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1;
    check_eq("rst_mid_moc", 32'(moc_w[0]), 32'h0);
    check_eq("rst_mid_data", dout_w[0], 32'h0);
    check_eq("rst_mid_state", 32'(st_w[0]), 32'h0);
    last_dout[0] = 32'h0;
    last_dout[1] = 32'h0;
    mov_d[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    do_op(0, 1'b1, 2'b10, 1'b0, 9'h040, 32'h0, 0, gd, ge);
    check_eq("rst_not_written", 32'(gd == 32'h11223344), 32'h0);
    do_op(0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 0, gd, ge);
    check_eq("rst_kept", gd, 32'hA1B2C3D4);

    // Random traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      do_op($urandom_range(0, 1), 1'($urandom), 2'($urandom_range(0, 3)),
            1'($urandom), AW'($urandom), $urandom, $urandom_range(0, 3), gd, ge);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
